// File: rtl/tt_um_rr_grant_sequencer.sv
// tt_um_rr_grant_sequencer: four-way round-robin grant sequencer with hold limit, lock and post-release gap.
// Optional TT_ARB_PRIORITY_EN: ui_in[7] with req[0] gives requester 0 the grant in IDLE, ptr untouched on release.
module tt_um_rr_grant_sequencer #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    state_t     state, state_nx;
    logic [3:0] grant, grant_nx, hold_cnt, hold_nx;
    logic [1:0] idx, idx_nx, ptr, ptr_nx, gap_cnt, gap_nx, win;
    logic       timeout, timeout_nx, prio_win, prio_nx, prio_hit;
    logic [3:0] req, limit;
    logic       lock, drop, at_lim, unused;
    assign req    = ui_in[3:0];
    assign lock   = ui_in[4];
    assign limit  = uio_in[3:0];
    assign unused = &{1'b0, ui_in[7:5], uio_in[7:4]};
    assign drop   = !req[idx];
    assign at_lim = limit != 4'd0 && hold_cnt == limit;
`ifdef TT_ARB_PRIORITY_EN
    assign prio_hit = ui_in[7] && req[0];
`else
    assign prio_hit = 1'b0;
`endif
    always_comb begin
        win = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + 2'(i)]) win = ptr + 2'(i);
        if (prio_hit) win = 2'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            idx      <= '0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            prio_win <= 1'b0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            idx      <= idx_nx;
            timeout  <= timeout_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            gap_cnt  <= gap_nx;
            prio_win <= prio_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        idx_nx     = idx;
        timeout_nx = 1'b0;
        ptr_nx     = ptr;
        hold_nx    = hold_cnt;
        gap_nx     = gap_cnt;
        prio_nx    = prio_win;
        if (!ena) begin
            state_nx = IDLE;
            grant_nx = '0;
        end else begin
            case (state)
                IDLE: if (req != 4'd0) begin
                    state_nx = GRANT;
                    grant_nx = 4'b1 << win;
                    idx_nx   = win;
                    hold_nx  = 4'd1;
                    prio_nx  = prio_hit;
                end
                GRANT: if (drop || (at_lim && !lock)) begin
                    state_nx   = GAP_CYCLES > 0 ? GAP : IDLE;
                    grant_nx   = '0;
                    timeout_nx = !drop;
                    ptr_nx     = prio_win ? ptr : idx + 2'd1;
                    gap_nx     = '0;
                end else begin
                    // a locked hold parks at the limit so dropping lock releases on the next edge
                    hold_nx = (at_lim || hold_cnt == 4'd15) ? hold_cnt : hold_cnt + 4'd1;
                end
                GAP: if (gap_cnt == GAP_LAST) state_nx = IDLE;
                     else gap_nx = gap_cnt + 2'd1;
                default: state_nx = IDLE;
            endcase
        end
    end
    assign uo_out  = {timeout, state == GRANT, idx, grant};
    assign uio_out = '0;
    assign uio_oe  = '0;
endmodule

// File: tb/tb_tt_um_rr_grant_sequencer.sv
// tb_tt_um_rr_grant_sequencer: directed test-plan steps then random traffic, checked against a behavioural arbiter model.
module tb_tt_um_rr_grant_sequencer;
    localparam int GAP = 1;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic [7:0] ui_in = '0, uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;
    int errors = 0, checks = 0;
    // model: st 0 idle, 1 grant, 2 gap; own = -1 when nothing granted
    int m_st, m_own, m_idx, m_ptr, m_hold, m_gap, m_pw;
    bit m_to;

    tt_um_rr_grant_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function void model_reset();
        m_st = 0; m_own = -1; m_idx = 0; m_ptr = 0; m_hold = 0; m_gap = 0; m_pw = 0; m_to = 0;
    endfunction

    function void model_release(bit t);
        if (m_pw == 0) m_ptr = (m_own + 1) % 4;
        m_own = -1;
        m_to = t;
        m_gap = 0;
        m_st = GAP > 0 ? 2 : 0;
    endfunction

    function void model_edge();
        int lim;
        lim = int'(uio_in[3:0]);
        m_to = 0;
        if (!ena) begin
            m_st = 0;
            m_own = -1;
        end else if (m_st == 0) begin
            for (int k = 0; k < 4; k++)
                if (m_own < 0 && ui_in[(m_ptr + k) % 4]) m_own = (m_ptr + k) % 4;
            m_pw = 0;
`ifdef TT_ARB_PRIORITY_EN
            if (ui_in[7] && ui_in[0]) begin m_own = 0; m_pw = 1; end
`endif
            if (m_own >= 0) begin m_st = 1; m_hold = 1; m_idx = m_own; end
        end else if (m_st == 1) begin
            if (!ui_in[m_own]) model_release(0);
            else if (lim != 0 && m_hold == lim && !ui_in[4]) model_release(1);
            else if (!(lim != 0 && m_hold == lim) && m_hold < 15) m_hold++;
        end else begin
            m_gap++;
            if (m_gap >= GAP) m_st = 0;
        end
    endfunction

    function logic [7:0] m_out();
        logic [7:0] e;
        e[3:0] = m_own >= 0 ? 4'(1 << m_own) : 4'd0;
        e[5:4] = 2'(m_idx);
        e[6] = m_st == 1;
        e[7] = m_to;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle", {8'd0, uo_out}, {8'd0, m_out()});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] ord;
        int tos, hi;
        logic pb;
        model_reset();
        ui_in = 8'h0f;
        #3 chk("reset_async", {8'd0, uo_out}, 16'h0000);
        repeat (2) @(posedge clk);
        #1 chk("reset_hold", {8'd0, uo_out}, 16'h0000);
        chk("uio_const", {uio_oe, uio_out}, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("first_grant", {8'd0, uo_out}, 16'h0041);
        // round robin with limit 3
        do_reset();
        uio_in = 8'h03;
        ord = '0; tos = 0; hi = 0; pb = 1'b0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (uo_out[6] && !pb) ord = {ord[13:0], uo_out[5:4]};
            pb = uo_out[6];
            tos += int'(uo_out[7]);
            hi += int'(uo_out[6]);
        end
        chk("rr_order", ord, 16'h006c);
        chk("rr_timeouts", 16'(tos), 16'd5);
        chk("rr_busy_cycles", 16'(hi), 16'd15);
        // lock holds past limit, dropping lock forces release
        do_reset();
        ui_in = 8'h12; uio_in = 8'h02; hi = 0; tos = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            hi += int'(uo_out[1]);
            tos += int'(uo_out[7]);
        end
        chk("lock_held", 16'(hi), 16'd10);
        chk("lock_no_timeout", 16'(tos), 16'd0);
        ui_in = 8'h02;
        tick();
        chk("lock_release", {8'd0, uo_out}, 16'h0090);
        // requester 2 alone, unlimited, released by dropping req
        ui_in = 8'h04; uio_in = 8'h00;
        tick();
        tick();
        chk("req2_grant", {8'd0, uo_out}, 16'h0064);
        repeat (4) tick();
        ui_in = 8'h00;
        tick();
        chk("req2_drop", {8'd0, uo_out}, 16'h0020);
        ui_in = 8'h0f;
        tick();
        tick();
        chk("scan_from_3", {8'd0, uo_out}, 16'h0078);
        // async reset mid-grant
        rst_n = 1'b0;
        #2 chk("async_mid_grant", {8'd0, uo_out}, 16'h0000);
        model_reset();
        rst_n = 1'b1;
        tick();
        chk("ptr_after_reset", {8'd0, uo_out}, 16'h0041);
        // priority input with ptr at 2
        do_reset();
        ui_in = 8'h02;
        tick();
        chk("prio_setup_grant", {8'd0, uo_out}, 16'h0052);
        ui_in = 8'h00;
        tick();
        ui_in = 8'h85;
        tick();
        tick();
`ifdef TT_ARB_PRIORITY_EN
        chk("prio_grant", {8'd0, uo_out}, 16'h0041);
`else
        chk("prio_ignored", {8'd0, uo_out}, 16'h0064);
`endif
        ui_in = 8'h00;
        tick();
        // random traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(3) == 0) ui_in[3:0] = 4'($urandom);
            ui_in[4] = $urandom_range(5) == 0;
            ui_in[7:5] = 3'($urandom);
            if ($urandom_range(19) == 0) uio_in = 8'($urandom);
            ena = $urandom_range(24) != 0;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
